// File: rtl/valid_delay_pipe_if.sv
// Handshake bundle for valid_delay_pipe: producer side, consumer side, flush and occupancy.
// master = the environment driving the pipe; slave = the pipe itself.
interface valid_delay_pipe_if #(
  parameter int unsigned CYCLES = 4,
  parameter int unsigned WIDTH  = 32
);
  localparam int unsigned CW = $clog2(CYCLES + 1);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/valid_delay_pipe.sv
// CYCLES-stage delay pipe with per-stage valid bits and valid/ready on both sides.
// Default build: a stalled output freezes every stage (global advance).
// Define VALID_DELAY_PIPE_COLLAPSE_EN for bubble collapsing: empty stages keep
// filling behind a stalled output, so up to CYCLES entries can pack up.
// in_ready depends combinationally on out_ready; all other outputs are registered.
module valid_delay_pipe #(
  parameter int unsigned      CYCLES   = 4,
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input logic               clk,
  input logic               rst_n,
  valid_delay_pipe_if.slave pipe_if
);

  localparam int unsigned CW = $clog2(CYCLES + 1);

  // Elaboration guard: the pipe needs at least one stage.
  if (CYCLES < 1) begin : g_cycles_check
    $error("valid_delay_pipe: CYCLES must be >= 1");
  end

  logic [CYCLES-1:0] v_q, v_d;
  logic [WIDTH-1:0]  d_q [CYCLES];
  logic [WIDTH-1:0]  d_d [CYCLES];
  logic [CW-1:0]     count_q, count_d;

  logic [CYCLES-1:0] adv_c;
  logic [CYCLES:0]   up_v_c;
  logic [WIDTH-1:0]  up_d_c [CYCLES+1];
  logic              in_ready_c;
  logic              in_fire_c;
  logic              out_fire_c;

`ifdef VALID_DELAY_PIPE_COLLAPSE_EN
  // Per-stage ready chain: a stage moves if it is empty or the stage after it moves.
  always_comb begin
    logic run;
    adv_c = '0;
    run   = pipe_if.out_ready;
    for (int j = 0; j < int'(CYCLES); j++) begin
      run                 = !v_q[CYCLES-1-j] | run;
      adv_c[CYCLES-1-j]   = run;
    end
  end
`else
  // Global advance: the whole pipe shifts unless a valid last stage is blocked.
  always_comb begin
    adv_c = {CYCLES{!v_q[CYCLES-1] | pipe_if.out_ready}};
  end
`endif

  // Handshake fire terms; entry is refused during flush.
  always_comb begin
    in_ready_c = adv_c[0] & !pipe_if.flush;
    in_fire_c  = pipe_if.in_valid & in_ready_c;
    out_fire_c = v_q[CYCLES-1] & pipe_if.out_ready;
  end

  // Upstream view of each stage: stage 0 sees the input port, stage i sees stage i-1.
  assign up_v_c = {v_q, in_fire_c};

  always_comb begin
    up_d_c[0] = pipe_if.in_data;
    for (int i = 0; i < int'(CYCLES); i++) begin
      up_d_c[i+1] = d_q[i];
    end
  end

  // Stage next-state: valid follows upstream on advance; data only loads real entries.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    for (int i = 0; i < int'(CYCLES); i++) begin
      if (adv_c[i]) begin
        v_d[i] = up_v_c[i];
        if (up_v_c[i]) begin
          d_d[i] = up_d_c[i];
        end
      end
    end
    if (pipe_if.flush) begin
      v_d = '0;
    end
  end

  // Occupancy tracks accepted minus delivered entries.
  always_comb begin
    count_d = count_q;
    case ({in_fire_c, out_fire_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (pipe_if.flush) begin
      count_d = '0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q     <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(CYCLES); i++) begin
        d_q[i] <= INIT_VAL;
      end
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      for (int i = 0; i < int'(CYCLES); i++) begin
        d_q[i] <= d_d[i];
      end
    end
  end

  assign pipe_if.in_ready  = in_ready_c;
  assign pipe_if.out_valid = v_q[CYCLES-1];
  assign pipe_if.out_data  = d_q[CYCLES-1];
  assign pipe_if.count     = count_q;

endmodule
